// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller: exception indices, CSR map,
// cause codes, FSM states and priority resolution.
package trap_controller_pkg;

  localparam int EXCEPTION_WIDTH = 4;
  localparam int ILLEGAL         = 0;
  localparam int ECALL           = 1;
  localparam int EBREAK          = 2;
  localparam int MRET            = 3;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP   = 1'b0,
    KIND_RETURN = 1'b1
  } trap_kind_e;

  // ILLEGAL > EBREAK > ECALL; MRET carries no cause.
  function automatic logic [3:0] resolve_cause(input logic [EXCEPTION_WIDTH-1:0] exc);
    if (exc[ILLEGAL])     return CAUSE_ILLEGAL;
    else if (exc[EBREAK]) return CAUSE_EBREAK;
    else if (exc[ECALL])  return CAUSE_ECALL;
    else                  return 4'd0;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Decode-side, pipeline and CSR port signals of the trap controller.
interface trap_controller_if
  import trap_controller_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int DWIDTH   = 32
);
  logic [EXCEPTION_WIDTH-1:0] t_i_exception;
  logic                       t_i_ce;
  logic [PC_WIDTH-1:0]        t_i_pc;
  logic                       t_i_pipe_empty;
  logic                       t_i_csr_we;
  logic [11:0]                t_i_csr_addr;
  logic [DWIDTH-1:0]          t_i_csr_wdata;
  logic [DWIDTH-1:0]          t_o_csr_rdata;
  logic                       t_o_stall;
  logic                       t_o_flush;
  logic                       t_o_pc_load;
  logic [PC_WIDTH-1:0]        t_o_pc_target;
  logic [DWIDTH-1:0]          t_o_mepc;
  logic [DWIDTH-1:0]          t_o_mcause;
  logic                       t_o_busy;

  modport master (
    output t_i_exception, t_i_ce, t_i_pc, t_i_pipe_empty,
           t_i_csr_we, t_i_csr_addr, t_i_csr_wdata,
    input  t_o_csr_rdata, t_o_stall, t_o_flush, t_o_pc_load,
           t_o_pc_target, t_o_mepc, t_o_mcause, t_o_busy
  );

  modport slave (
    input  t_i_exception, t_i_ce, t_i_pc, t_i_pipe_empty,
           t_i_csr_we, t_i_csr_addr, t_i_csr_wdata,
    output t_o_csr_rdata, t_o_stall, t_o_flush, t_o_pc_load,
           t_o_pc_target, t_o_mepc, t_o_mcause, t_o_busy
  );
endinterface

// File: rtl/trap_csr_file.sv
// Machine trap CSRs (mtvec, mepc, mcause): software writes, hardware trap
// update and combinational read mux.
module trap_csr_file
  import trap_controller_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_we_i,
  input  logic [11:0]       csr_addr_i,
  input  logic [DWIDTH-1:0] csr_wdata_i,
  input  logic              hw_we_i,
  input  logic [DWIDTH-1:0] hw_epc_i,
  input  logic [DWIDTH-1:0] hw_cause_i,
  output logic [DWIDTH-1:0] csr_rdata_o,
  output logic [DWIDTH-1:0] mtvec_o,
  output logic [DWIDTH-1:0] mepc_o,
  output logic [DWIDTH-1:0] mcause_o
);

  logic [DWIDTH-1:0] mtvec_q, mtvec_d;
  logic [DWIDTH-1:0] mepc_q, mepc_d;
  logic [DWIDTH-1:0] mcause_q, mcause_d;

  // Hardware trap update is applied last so it beats a same-cycle software write.
  always_comb begin
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (csr_we_i) begin
      case (csr_addr_i)
        CSR_MTVEC:  mtvec_d  = {csr_wdata_i[DWIDTH-1:2], 2'b00};
        CSR_MEPC:   mepc_d   = {csr_wdata_i[DWIDTH-1:2], 2'b00};
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
    if (hw_we_i) begin
      mepc_d   = {hw_epc_i[DWIDTH-1:2], 2'b00};
      mcause_d = hw_cause_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtvec_q  <= TRAP_VECTOR;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      default: ;
    endcase
  end

  assign mtvec_o  = mtvec_q;
  assign mepc_o   = mepc_q;
  assign mcause_o = mcause_q;

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: accepts a decode-stage exception, drains the back end,
// flushes the front end, updates the trap CSRs and redirects the PC.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int                PC_WIDTH    = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  trap_controller_if.slave bus
);

  trap_state_e         state_q, state_d;
  trap_kind_e          kind_q, kind_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          cause_q, cause_d;

  logic                trap_bits, take;
  logic                hw_we, flush, pc_load;
  logic [PC_WIDTH-1:0] pc_target;
  logic [DWIDTH-1:0]   mtvec, mepc, mcause;

  assign trap_bits = bus.t_i_exception[ILLEGAL] | bus.t_i_exception[ECALL]
                   | bus.t_i_exception[EBREAK];
  assign take      = bus.t_i_ce & (trap_bits | bus.t_i_exception[MRET]);

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    hw_we     = 1'b0;
    flush     = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          pc_d    = bus.t_i_pc;
          cause_d = resolve_cause(bus.t_i_exception);
          kind_d  = trap_bits ? KIND_TRAP : KIND_RETURN;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.t_i_pipe_empty) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        hw_we   = (kind_q == KIND_TRAP);
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_load   = 1'b1;
        pc_target = (kind_q == KIND_TRAP) ? PC_WIDTH'(mtvec) : PC_WIDTH'(mepc);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_TRAP;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  trap_csr_file #(
    .DWIDTH      (DWIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .csr_we_i    (bus.t_i_csr_we),
    .csr_addr_i  (bus.t_i_csr_addr),
    .csr_wdata_i (bus.t_i_csr_wdata),
    .hw_we_i     (hw_we),
    .hw_epc_i    (DWIDTH'(pc_q)),
    .hw_cause_i  (DWIDTH'(cause_q)),
    .csr_rdata_o (bus.t_o_csr_rdata),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc),
    .mcause_o    (mcause)
  );

  assign bus.t_o_stall     = (state_q != ST_IDLE);
  assign bus.t_o_busy      = (state_q != ST_IDLE);
  assign bus.t_o_flush     = flush;
  assign bus.t_o_pc_load   = pc_load;
  assign bus.t_o_pc_target = pc_target;
  assign bus.t_o_mepc      = mepc;
  assign bus.t_o_mcause    = mcause;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: vector table, hand-written corner
// sequences and randomized traps against a CSR/priority reference model.
module tb_trap_controller;
  import trap_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_controller_if #(.PC_WIDTH(32), .DWIDTH(32)) bus();

  trap_controller #(
    .PC_WIDTH    (32),
    .DWIDTH      (32),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mtvec, m_mepc, m_mcause;

  typedef struct {
    logic [3:0]  exc;
    logic [31:0] pc;
    int          wait_n;
    int          cause;   // 0 means trap return
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int model_cause(input logic [3:0] exc);
    int order[3] = '{ILLEGAL, EBREAK, ECALL};
    int codes[3] = '{2, 3, 11};
    for (int i = 0; i < 3; i++)
      if (exc[order[i]]) return codes[i];
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    if (addr == CSR_MTVEC)  return m_mtvec;
    if (addr == CSR_MEPC)   return m_mepc;
    if (addr == CSR_MCAUSE) return m_mcause;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_mtvec  = 32'h0000_0100;
    m_mepc   = 32'h0;
    m_mcause = 32'h0;
  endtask

  task automatic idle_inputs();
    bus.t_i_exception  = '0;
    bus.t_i_ce         = 1'b0;
    bus.t_i_pc         = '0;
    bus.t_i_pipe_empty = 1'b1;
    bus.t_i_csr_we     = 1'b0;
    bus.t_i_csr_addr   = '0;
    bus.t_i_csr_wdata  = '0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.t_i_csr_we    = 1'b1;
    bus.t_i_csr_addr  = addr;
    bus.t_i_csr_wdata = data;
    @(posedge clk);
    #1;
    bus.t_i_csr_we = 1'b0;
    if (addr == CSR_MTVEC)  m_mtvec  = data & 32'hFFFF_FFFC;
    if (addr == CSR_MEPC)   m_mepc   = data & 32'hFFFF_FFFC;
    if (addr == CSR_MCAUSE) m_mcause = data;
  endtask

  task automatic csr_read_chk(input string name, input logic [11:0] addr);
    @(negedge clk);
    bus.t_i_csr_addr = addr;
    #1;
    chk(name, bus.t_o_csr_rdata, model_read(addr));
  endtask

  // Raise one exception and follow the whole sequence back to IDLE.
  task automatic run_trap(input string tag, input logic [3:0] exc, input logic [31:0] pc,
                          input int wait_n, input int cause, input logic coll_en,
                          input logic [11:0] coll_addr, input logic [31:0] coll_data);
    logic        is_trap;
    logic [31:0] exp_tgt, tgt;
    int          stall_cnt, flush_cnt, flush_at, load_at;
    logic        done;
    is_trap = (cause != 0);
    @(negedge clk);
    bus.t_i_ce         = 1'b1;
    bus.t_i_exception  = exc;
    bus.t_i_pc         = pc;
    bus.t_i_pipe_empty = (wait_n == 0);
    @(posedge clk);
    #1;
    if (coll_en) begin
      if (coll_addr == CSR_MTVEC) m_mtvec = coll_data & 32'hFFFF_FFFC;
      if (coll_addr == CSR_MEPC && !is_trap) m_mepc = coll_data & 32'hFFFF_FFFC;
      if (coll_addr == CSR_MCAUSE && !is_trap) m_mcause = coll_data;
    end
    if (is_trap) begin
      m_mepc   = pc & 32'hFFFF_FFFC;
      m_mcause = cause;
      exp_tgt  = m_mtvec;
    end else begin
      exp_tgt = m_mepc;
    end
    stall_cnt = 0; flush_cnt = 0; flush_at = 0; load_at = 0; tgt = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (!bus.t_o_stall) begin
        done = 1'b1;
        chk({tag, " idle busy"}, bus.t_o_busy, 1'b0);
      end else begin
        stall_cnt++;
        if (bus.t_o_flush) begin flush_cnt++; flush_at = c; end
        if (bus.t_o_pc_load) begin
          load_at = c;
          tgt     = bus.t_o_pc_target;
          chk({tag, " mepc"}, bus.t_o_mepc, m_mepc);
          chk({tag, " mcause"}, bus.t_o_mcause, m_mcause);
        end
        bus.t_i_pipe_empty = (c > wait_n);
        bus.t_i_ce         = (c <= wait_n + 2);
        bus.t_i_exception  = 4'b0001;
        bus.t_i_pc         = 32'hDEAD_BEEF;
        bus.t_i_csr_we     = coll_en && (c == wait_n + 2);
        bus.t_i_csr_addr   = coll_addr;
        bus.t_i_csr_wdata  = coll_data;
        @(posedge clk);
        #1;
      end
    end
    idle_inputs();
    chk({tag, " timeout"}, done, 1'b1);
    chk({tag, " stall cycles"}, stall_cnt, wait_n + 3);
    chk({tag, " flush count"}, flush_cnt, 1);
    chk({tag, " flush cycle"}, flush_at, wait_n + 2);
    chk({tag, " load cycle"}, load_at, wait_n + 3);
    chk({tag, " target"}, tgt, exp_tgt);
  endtask

  vec_t tbl[5];

  initial begin
    logic [11:0] raddrs[4];
    model_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", bus.t_o_stall, 1'b0);
    chk("reset busy", bus.t_o_busy, 1'b0);
    chk("reset flush", bus.t_o_flush, 1'b0);
    chk("reset pc_load", bus.t_o_pc_load, 1'b0);
    chk("reset target", bus.t_o_pc_target, 32'h0);
    chk("reset mepc", bus.t_o_mepc, 32'h0);
    chk("reset mcause", bus.t_o_mcause, 32'h0);
    bus.t_i_csr_addr = CSR_MTVEC;
    #1;
    chk("reset mtvec", bus.t_o_csr_rdata, 32'h0000_0100);
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{exc: 4'b0010, pc: 32'h0000_0040, wait_n: 0, cause: 11};
    tbl[1] = '{exc: 4'b0011, pc: 32'h0000_0080, wait_n: 3, cause: 2};
    tbl[2] = '{exc: 4'b1110, pc: 32'h0000_0123, wait_n: 1, cause: 3};
    tbl[3] = '{exc: 4'b1000, pc: 32'h0000_0777, wait_n: 0, cause: 0};
    tbl[4] = '{exc: 4'b1001, pc: 32'h0000_1002, wait_n: 2, cause: 2};
    for (int i = 0; i < 5; i++)
      run_trap($sformatf("vec%0d", i), tbl[i].exc, tbl[i].pc, tbl[i].wait_n,
               tbl[i].cause, 1'b0, 12'h0, 32'h0);

    // Software mepc followed by MRET returns there and leaves CSRs alone.
    csr_write(CSR_MEPC, 32'h0000_0200);
    csr_read_chk("mepc readback", CSR_MEPC);
    run_trap("mret", 4'b1000, 32'h0000_0050, 0, 0, 1'b0, 12'h0, 32'h0);
    chk("mret mepc kept", bus.t_o_mepc, 32'h0000_0200);
    chk("mret mcause kept", bus.t_o_mcause, 32'd2);

    csr_write(CSR_MTVEC, 32'h0000_0303);
    csr_read_chk("mtvec aligned", CSR_MTVEC);
    chk("mtvec 0x300", model_read(CSR_MTVEC) ^ bus.t_o_csr_rdata ^ 32'h300, 32'h300);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_read_chk("unmapped read", 12'h7C0);
    csr_read_chk("mcause after unmapped", CSR_MCAUSE);

    // Writes landing in the FLUSH cycle of a trap.
    run_trap("coll mtvec", 4'b0010, 32'h0000_0084, 1, 11, 1'b1, CSR_MTVEC, 32'h0000_0500);
    run_trap("coll mepc", 4'b0001, 32'h0000_0090, 0, 2, 1'b1, CSR_MEPC, 32'h0000_0ABC);
    run_trap("coll mcause", 4'b0100, 32'h0000_0094, 2, 3, 1'b1, CSR_MCAUSE, 32'h0000_0007);
    csr_read_chk("coll mepc readback", CSR_MEPC);

    // Exception bits without decode valid are ignored.
    @(negedge clk);
    bus.t_i_ce        = 1'b0;
    bus.t_i_exception = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("no ce busy%0d", i), bus.t_o_busy, 1'b0);
    end
    idle_inputs();

    raddrs = '{CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, 12'h300};
    for (int i = 0; i < 25; i++) begin
      logic [3:0] exc;
      logic       coll;
      if ($urandom_range(0, 2) == 0)
        csr_write(raddrs[$urandom_range(0, 3)], $urandom);
      exc  = 4'($urandom_range(1, 15));
      coll = ($urandom_range(0, 3) == 0);
      run_trap($sformatf("rnd%0d", i), exc, $urandom, $urandom_range(0, 3),
               model_cause(exc), coll, raddrs[$urandom_range(0, 3)], $urandom);
    end

    // Reset while draining aborts without any CSR update or redirect.
    @(negedge clk);
    bus.t_i_ce         = 1'b1;
    bus.t_i_exception  = 4'b0010;
    bus.t_i_pc         = 32'h0000_0044;
    bus.t_i_pipe_empty = 1'b0;
    @(posedge clk);
    #1;
    bus.t_i_ce = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset stall", bus.t_o_stall, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst stall", bus.t_o_stall, 1'b0);
    chk("rst busy", bus.t_o_busy, 1'b0);
    chk("rst flush", bus.t_o_flush, 1'b0);
    chk("rst pc_load", bus.t_o_pc_load, 1'b0);
    chk("rst mepc", bus.t_o_mepc, 32'h0);
    chk("rst mcause", bus.t_o_mcause, 32'h0);
    bus.t_i_csr_addr = CSR_MTVEC;
    #1;
    chk("rst mtvec", bus.t_o_csr_rdata, 32'h0000_0100);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    run_trap("post reset", 4'b0100, 32'h0000_0060, 0, 3, 1'b0, 12'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
